// File: rtl/madd_eval_pkg.sv
// Shared definitions for the approximate multiply-add error monitor:
// FSM state encoding, operand field positions and the exact a*b+c model.
package madd_eval_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Operand fields inside a 6-bit input vector: a=[1:0], b=[3:2], c=[5:4]
   localparam int FIELD_W = 2;
   localparam int A_LSB   = 0;
   localparam int B_LSB   = 2;
   localparam int C_LSB   = 4;

   // Exact reference result a*b+c; the largest value (3*3+3=12) fits in 4 bits
   function automatic logic [3:0] madd_exact(input logic [5:0] vec);
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] c;
      a = {2'b00, vec[A_LSB +: FIELD_W]};
      b = {2'b00, vec[B_LSB +: FIELD_W]};
      c = {2'b00, vec[C_LSB +: FIELD_W]};
      return (a * b) + c;
   endfunction

endpackage

// File: rtl/madd_exact_ref.sv
// Combinational exact multiply-add model. Zero-extends the vector into the
// 6-bit operand layout and returns a*b+c in N_OUT bits.
module madd_exact_ref
   import madd_eval_pkg::*;
#(
   parameter int N_IN  = 6,
   parameter int N_OUT = 4
) (
   input  logic [N_IN-1:0]  vec_i,
   output logic [N_OUT-1:0] exact_o
);

   logic [5:0] vec6;

   // Fit the incoming vector to the fixed operand layout and evaluate the model
   always_comb begin
      vec6    = 6'(vec_i);
      exact_o = N_OUT'(madd_exact(vec6));
   end

endmodule

// File: rtl/madd_error_monitor.sv
// Sweep-and-compare harness for approximate multiply-add netlists.
// Drives every input vector once, lines the DUT output up with the vector
// that produced it, and accumulates max error, error sum and the number of
// vectors whose error exceeds the threshold.
module madd_error_monitor
   import madd_eval_pkg::*;
#(
   parameter int N_IN    = 6,
   parameter int N_OUT   = 4,
   parameter int ET      = 2,
   parameter int DUT_LAT = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [N_IN-1:0]       stim,
   output logic                  stim_vld,
   input  logic [N_OUT-1:0]      approx_in,
   output logic [N_OUT-1:0]      max_err,
   output logic [N_IN+N_OUT-1:0] err_sum,
   output logic [N_IN:0]         viol_cnt,
   output logic                  pass
);

   localparam logic [N_OUT-1:0] ET_V       = N_OUT'(ET);
   localparam logic [2:0]       DRAIN_LAST = (DUT_LAT > 0) ? 3'(DUT_LAT - 1) : 3'd0;

   state_e                 state_q, state_d;
   logic [N_IN:0]          cnt_q, cnt_d, cntInc;
   logic [2:0]             drain_q, drain_d;
   logic                   startSweep;
   logic                   enterDone;

   logic [N_IN-1:0]        dlyStim;
   logic                   dlyVld;
   logic [N_OUT-1:0]       exactVal;
   logic signed [N_OUT:0]  diff;
   logic [N_OUT-1:0]       errMag;

   logic [N_OUT-1:0]       maxErr_q, maxErr_d;
   logic [N_IN+N_OUT-1:0]  errSum_q, errSum_d;
   logic [N_IN:0]          violCnt_q, violCnt_d;
   logic                   pass_q, pass_d;

   // The extra counter bit flags the last vector: cnt+1 carries into it
   assign cntInc = cnt_q + (N_IN+1)'(1);

   // State, vector counter and drain counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drain_q <= drain_d;
      end
   end

   // Next-state logic: walk every vector once, wait out the DUT pipeline, pulse done
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      drain_d    = drain_q;
      startSweep = 1'b0;
      enterDone  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = SWEEP;
               cnt_d      = '0;
               startSweep = 1'b1;
            end
         end
         SWEEP: begin
            if (cntInc[N_IN]) begin
               if (DUT_LAT > 0) begin
                  state_d = DRAIN;
                  drain_d = '0;
               end else begin
                  state_d   = DONE;
                  enterDone = 1'b1;
               end
            end else begin
               cnt_d = cntInc;
            end
         end
         DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d   = DONE;
               enterDone = 1'b1;
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign stim     = cnt_q[N_IN-1:0];
   assign stim_vld = (state_q == SWEEP);
   assign busy     = (state_q == SWEEP) || (state_q == DRAIN);
   assign done     = (state_q == DONE);

   // Delay stim/stim_vld by the DUT latency so each sample meets its own vector
   generate
      if (DUT_LAT == 0) begin : g_noDelay
         assign dlyStim = stim;
         assign dlyVld  = stim_vld;
      end else begin : g_delay
         logic [N_IN-1:0]    stimPipe_q [DUT_LAT];
         logic [DUT_LAT-1:0] vldPipe_q;

         // Shift register carrying the issued vector alongside its valid flag
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vldPipe_q <= '0;
               for (int i = 0; i < DUT_LAT; i++) begin
                  stimPipe_q[i] <= '0;
               end
            end else begin
               vldPipe_q[0]  <= stim_vld;
               stimPipe_q[0] <= stim;
               for (int i = 1; i < DUT_LAT; i++) begin
                  vldPipe_q[i]  <= vldPipe_q[i-1];
                  stimPipe_q[i] <= stimPipe_q[i-1];
               end
            end
         end

         assign dlyStim = stimPipe_q[DUT_LAT-1];
         assign dlyVld  = vldPipe_q[DUT_LAT-1];
      end
   endgenerate

   madd_exact_ref #(
      .N_IN  (N_IN),
      .N_OUT (N_OUT)
   ) u_exact (
      .vec_i   (dlyStim),
      .exact_o (exactVal)
   );

   // Absolute error between the exact model and the DUT sample
   always_comb begin
      diff   = $signed({1'b0, exactVal}) - $signed({1'b0, approx_in});
      errMag = diff[N_OUT] ? N_OUT'(-diff) : diff[N_OUT-1:0];
   end

   // Accumulator update: clear on sweep start, fold in each aligned sample, latch pass on entry to DONE
   always_comb begin
      maxErr_d  = maxErr_q;
      errSum_d  = errSum_q;
      violCnt_d = violCnt_q;
      pass_d    = pass_q;
      if (startSweep) begin
         maxErr_d  = '0;
         errSum_d  = '0;
         violCnt_d = '0;
         pass_d    = 1'b0;
      end else if (dlyVld) begin
         errSum_d  = errSum_q + (N_IN+N_OUT)'(errMag);
         violCnt_d = violCnt_q + (N_IN+1)'(errMag > ET_V);
         if (errMag > maxErr_q) begin
            maxErr_d = errMag;
         end
      end
      if (enterDone) begin
         pass_d = (maxErr_d <= ET_V);
      end
   end

   // Accumulator registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         maxErr_q  <= '0;
         errSum_q  <= '0;
         violCnt_q <= '0;
         pass_q    <= 1'b0;
      end else begin
         maxErr_q  <= maxErr_d;
         errSum_q  <= errSum_d;
         violCnt_q <= violCnt_d;
         pass_q    <= pass_d;
      end
   end

   assign max_err  = maxErr_q;
   assign err_sum  = errSum_q;
   assign viol_cnt = violCnt_q;
   assign pass     = pass_q;

endmodule

// File: tb/tb_madd_error_monitor.sv
// Bench for madd_error_monitor: one combinational-DUT instance and one
// instance facing a two-stage registered DUT, both fed from a lookup table
// of approximate results (golden, stuck-at-zero, LSB-flipped or random).
module tb_madd_error_monitor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       startReq;
   logic       sel;

   logic       start0, busy0, done0, stimVld0, pass0;
   logic [5:0] stim0;
   logic [3:0] approx0, maxErr0;
   logic [9:0] errSum0;
   logic [6:0] violCnt0;

   logic       start1, busy1, done1, stimVld1, pass1;
   logic [5:0] stim1;
   logic [3:0] approx1, maxErr1;
   logic [9:0] errSum1;
   logic [6:0] violCnt1;

   logic [3:0] lut [64];
   logic [3:0] pipeA, pipeB;

   logic       obsBusy, obsDone, obsVld, obsPass;
   logic [5:0] obsStim;
   logic [3:0] obsMaxErr;
   logic [9:0] obsErrSum;
   logic [6:0] obsViolCnt;

   int checks = 0;
   int errors = 0;

   // Free-running clock
   always #5 clk = ~clk;

   assign start0 = startReq & ~sel;
   assign start1 = startReq & sel;

   // Combinational approximate DUT for the zero-latency instance
   always_comb approx0 = lut[stim0];

   // Same table behind two register stages for the latency-2 instance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipeA <= '0;
         pipeB <= '0;
      end else begin
         pipeA <= lut[stim1];
         pipeB <= pipeA;
      end
   end
   assign approx1 = pipeB;

   // Route the instance under test to a common set of observation signals
   always_comb begin
      if (sel) begin
         obsBusy = busy1; obsDone = done1; obsVld = stimVld1; obsPass = pass1;
         obsStim = stim1; obsMaxErr = maxErr1; obsErrSum = errSum1; obsViolCnt = violCnt1;
      end else begin
         obsBusy = busy0; obsDone = done0; obsVld = stimVld0; obsPass = pass0;
         obsStim = stim0; obsMaxErr = maxErr0; obsErrSum = errSum0; obsViolCnt = violCnt0;
      end
   end

   madd_error_monitor #(.N_IN(6), .N_OUT(4), .ET(2), .DUT_LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
      .stim(stim0), .stim_vld(stimVld0), .approx_in(approx0), .max_err(maxErr0),
      .err_sum(errSum0), .viol_cnt(violCnt0), .pass(pass0)
   );

   madd_error_monitor #(.N_IN(6), .N_OUT(4), .ET(2), .DUT_LAT(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
      .stim(stim1), .stim_vld(stimVld1), .approx_in(approx1), .max_err(maxErr1),
      .err_sum(errSum1), .viol_cnt(violCnt1), .pass(pass1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Table of DUT answers: 0 golden, 1 stuck at zero, 2 exact with LSB flipped, 3 random
   task automatic fillLut(input int mode);
      int ex;
      for (int i = 0; i < 64; i++) begin
         ex = (i % 4) * ((i / 4) % 4) + (i / 16);
         case (mode)
            0:       lut[i] = 4'(ex);
            1:       lut[i] = 4'd0;
            2:       lut[i] = 4'(ex ^ 1);
            default: lut[i] = 4'($urandom_range(0, 15));
         endcase
      end
   endtask

   // Reference figures for a whole sweep over the current table
   task automatic computeModel(output int expMax, output int expSum, output int expViol, output int expPass);
      int ex, e;
      expMax = 0; expSum = 0; expViol = 0;
      for (int i = 0; i < 64; i++) begin
         ex = (i % 4) * ((i / 4) % 4) + (i / 16);
         e  = ex - int'(lut[i]);
         if (e < 0) e = -e;
         expSum += e;
         if (e > expMax) expMax = e;
         if (e > 2) expViol++;
      end
      expPass = (expMax <= 2) ? 1 : 0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_stim"}, 32'(obsStim), 0);
      checkOutput({tag, "_vld"}, 32'(obsVld), 0);
      checkOutput({tag, "_busy"}, 32'(obsBusy), 0);
      checkOutput({tag, "_done"}, 32'(obsDone), 0);
      checkOutput({tag, "_maxErr"}, 32'(obsMaxErr), 0);
      checkOutput({tag, "_errSum"}, 32'(obsErrSum), 0);
      checkOutput({tag, "_violCnt"}, 32'(obsViolCnt), 0);
      checkOutput({tag, "_pass"}, 32'(obsPass), 0);
   endtask

   // One sweep on the chosen instance; optionally re-pulse start or reset mid-sweep
   task automatic applyStimulus(input string name, input bit useLat2, input int mode,
                                input bit repulse, input int resetAt);
      int  expMax, expSum, expViol, expPass;
      int  lat, doneCycle, vldCount, seqErrs;
      bit  clearStart;
      fillLut(mode);
      computeModel(expMax, expSum, expViol, expPass);
      lat        = useLat2 ? 2 : 0;
      sel        = useLat2;
      doneCycle  = 0;
      vldCount   = 0;
      seqErrs    = 0;
      clearStart = 1'b0;
      @(negedge clk);
      startReq = 1'b1;
      @(negedge clk);
      startReq = 1'b0;
      checkOutput({name, "_busyAtStart"}, 32'(obsBusy), 1);
      for (int c = 1; c <= 300; c++) begin
         if (clearStart) begin
            startReq   = 1'b0;
            clearStart = 1'b0;
         end
         if (obsDone) begin
            doneCycle = c;
            break;
         end
         if (obsVld) begin
            if (int'(obsStim) != vldCount) seqErrs++;
            if (resetAt >= 0 && int'(obsStim) == resetAt) begin
               rst_n = 1'b0;
               #1;
               checkAllZero({name, "_rst"});
               @(negedge clk);
               rst_n = 1'b1;
               return;
            end
            if (repulse && int'(obsStim) == 10) begin
               startReq   = 1'b1;
               clearStart = 1'b1;
            end
            vldCount++;
         end
         @(negedge clk);
      end
      startReq = 1'b0;
      if (doneCycle == 0) begin
         checkOutput({name, "_doneTimeout"}, 0, 1);
         return;
      end
      checkOutput({name, "_doneCycle"}, 32'(doneCycle), 32'(65 + lat));
      checkOutput({name, "_vldCycles"}, 32'(vldCount), 64);
      checkOutput({name, "_stimOrder"}, 32'(seqErrs), 0);
      checkOutput({name, "_maxErr"}, 32'(obsMaxErr), 32'(expMax));
      checkOutput({name, "_errSum"}, 32'(obsErrSum), 32'(expSum));
      checkOutput({name, "_violCnt"}, 32'(obsViolCnt), 32'(expViol));
      checkOutput({name, "_pass"}, 32'(obsPass), 32'(expPass));
      @(negedge clk);
      checkOutput({name, "_donePulse"}, 32'(obsDone), 0);
      checkOutput({name, "_busyAfter"}, 32'(obsBusy), 0);
      checkOutput({name, "_errSumHeld"}, 32'(obsErrSum), 32'(expSum));
      checkOutput({name, "_passHeld"}, 32'(obsPass), 32'(expPass));
   endtask

   // Test sequence
   initial begin
      rst_n    = 1'b0;
      startReq = 1'b0;
      sel      = 1'b0;
      fillLut(0);
      repeat (3) @(negedge clk);
      checkAllZero("reset0");
      sel = 1'b1;
      #1;
      checkAllZero("reset1");
      rst_n = 1'b1;

      applyStimulus("golden",      1'b0, 0, 1'b0, -1);
      applyStimulus("zero",        1'b0, 1, 1'b0, -1);
      applyStimulus("xorLsb",      1'b0, 2, 1'b0, -1);
      applyStimulus("goldenLat2",  1'b1, 0, 1'b0, -1);
      applyStimulus("zeroLat2",    1'b1, 1, 1'b0, -1);
      applyStimulus("restart",     1'b0, 0, 1'b1, -1);
      applyStimulus("resetMid",    1'b0, 3, 1'b0, 20);
      applyStimulus("afterReset",  1'b0, 3, 1'b0, -1);
      for (int r = 0; r < 3; r++) begin
         applyStimulus("random",     1'b0, 3, 1'b0, -1);
         applyStimulus("randomLat2", 1'b1, 3, 1'b0, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
